// File: rtl/uart_rx_engine.sv
// Receive-side control engine for an 8N1 UART: synchronises rx, qualifies start bits,
// times mid-bit shift strobes for the external Rx shift register and unpacks the frame.
module uart_rx_engine #(
    parameter int unsigned MinBt = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    input  logic [18:0] bit_time_i,
    input  logic [9:0]  frame_in_i,
    input  logic        rd_i,
    output logic        sdi_o,
    output logic        sh_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_rdy_o,
    output logic        ferr_o,
    output logic        ovf_o
);

    localparam logic [18:0] MinBtW = 19'(MinBt);

    typedef enum logic [2:0] {StIdle, StStart, StShift, StWait, StLoad} state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [18:0] tick_q, tick_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [18:0] bt_q, bt_d;
    logic        sh_q, sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_rdy_q, rx_rdy_d;
    logic        ferr_q, ferr_d;
    logic        ovf_q, ovf_d;

    logic [18:0] half_m1;
    logic [18:0] bt_m1;

    // Synchroniser resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    assign sdi_o   = sync2_q;
    assign half_m1 = (bt_q >> 1) - 19'd1;
    assign bt_m1   = bt_q - 19'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bitcnt_q  <= '0;
            bt_q      <= MinBtW;
            sh_q      <= 1'b0;
            rx_data_q <= '0;
            rx_rdy_q  <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bitcnt_q  <= bitcnt_d;
            bt_q      <= bt_d;
            sh_q      <= sh_d;
            rx_data_q <= rx_data_d;
            rx_rdy_q  <= rx_rdy_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bitcnt_d  = bitcnt_q;
        bt_d      = bt_q;
        sh_d      = 1'b0;
        rx_data_d = rx_data_q;
        rx_rdy_d  = rx_rdy_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;

        // A CPU read outside LOAD clears status; in LOAD the new byte takes priority.
        if (rd_i && state_q != StLoad) begin
            rx_rdy_d = 1'b0;
            ovf_d    = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (!sync2_q) begin
                    state_d  = StStart;
                    tick_d   = '0;
                    bitcnt_d = '0;
                    bt_d     = (bit_time_i < MinBtW) ? MinBtW : bit_time_i;
                end
            end
            StStart: begin
                if (tick_q == half_m1) begin
                    tick_d = '0;
                    if (!sync2_q) begin
                        sh_d     = 1'b1;
                        bitcnt_d = 4'd1;
                        state_d  = StShift;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    tick_d = tick_q + 19'd1;
                end
            end
            StShift: begin
                if (tick_q == bt_m1) begin
                    tick_d   = '0;
                    sh_d     = 1'b1;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        state_d = StWait;
                    end
                end else begin
                    tick_d = tick_q + 19'd1;
                end
            end
            StWait: begin
                tick_d  = '0;
                state_d = StLoad;
            end
            StLoad: begin
                rx_data_d = frame_in_i[8:1];
                ferr_d    = ~frame_in_i[9];
                rx_rdy_d  = 1'b1;
                ovf_d     = rd_i ? 1'b0 : (ovf_q | rx_rdy_q);
                tick_d    = '0;
                state_d   = StIdle;
            end
            default: begin
                tick_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign sh_o      = sh_q;
    assign rx_data_o = rx_data_q;
    assign rx_rdy_o  = rx_rdy_q;
    assign ferr_o    = ferr_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine with a 10-bit Rx shift register model fed by sdi/sh.
module tb_uart_rx_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_i;
    logic [18:0] bit_time_i;
    logic [9:0]  frame_in_i;
    logic        rd_i;
    logic        sdi_o;
    logic        sh_o;
    logic [7:0]  rx_data_o;
    logic        rx_rdy_o;
    logic        ferr_o;
    logic        ovf_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int sh_cyc[$];

    uart_rx_engine dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .bit_time_i (bit_time_i),
        .frame_in_i (frame_in_i),
        .rd_i       (rd_i),
        .sdi_o      (sdi_o),
        .sh_o       (sh_o),
        .rx_data_o  (rx_data_o),
        .rx_rdy_o   (rx_rdy_o),
        .ferr_o     (ferr_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    // Rx shift register: first bit received ends up in [0].
    always @(posedge clk or posedge rst) begin
        if (rst) frame_in_i <= '1;
        else if (sh_o) frame_in_i <= {sdi_o, frame_in_i[9:1]};
    end

    // Record the cycle number of every sh pulse.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sh_o) sh_cyc.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [9:0] bits, input int nbits, input int bpc);
        for (int i = 0; i < nbits; i++) begin
            rx_i = bits[i];
            repeat (bpc) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int bpc);
        send_bits({stop, data, 1'b0}, 10, bpc);
        rx_i = 1'b1;
        repeat (3 * bpc) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int base, input int bpc);
        int bad;
        bad = 0;
        check_eq({tag, "_shcnt"}, 32'(sh_cyc.size() - base), 32'd10);
        for (int i = base + 1; i < sh_cyc.size(); i++) begin
            if (sh_cyc[i] - sh_cyc[i-1] != bpc) bad++;
        end
        check_eq({tag, "_shgap"}, 32'(bad), 32'd0);
    endtask

    task automatic pulse_rd();
        rd_i = 1'b1;
        @(negedge clk);
        rd_i = 1'b0;
        @(negedge clk);
    endtask

    // Raise rd for exactly the LOAD cycle, which follows the 10th sh pulse.
    task automatic rd_at_load();
        int seen;
        int budget;
        seen   = 0;
        budget = 2000;
        while (seen < 10 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (sh_o) seen++;
        end
        check_eq("rdload_wait", 32'(seen), 32'd10);
        @(negedge clk);
        rd_i = 1'b1;
        @(negedge clk);
        rd_i = 1'b0;
    endtask

    initial begin
        int base;
        rst        = 1'b1;
        rx_i       = 1'b1;
        rd_i       = 1'b0;
        bit_time_i = 19'd16;
        repeat (3) @(negedge clk);
        check_eq("rst_sdi", 32'(sdi_o), 32'd1);
        check_eq("rst_sh", 32'(sh_o), 32'd0);
        check_eq("rst_data", 32'(rx_data_o), 32'd0);
        check_eq("rst_rdy", 32'(rx_rdy_o), 32'd0);
        check_eq("rst_ferr", 32'(ferr_o), 32'd0);
        check_eq("rst_ovf", 32'(ovf_o), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Good frame 0x55 at 16 clk/bit
        base = sh_cyc.size();
        send_frame(8'h55, 1'b1, 16);
        check_frame("f55", base, 16);
        check_eq("f55_data", 32'(rx_data_o), 32'h55);
        check_eq("f55_rdy", 32'(rx_rdy_o), 32'd1);
        check_eq("f55_ferr", 32'(ferr_o), 32'd0);
        check_eq("f55_ovf", 32'(ovf_o), 32'd0);
        pulse_rd();
        check_eq("rd1_rdy", 32'(rx_rdy_o), 32'd0);

        // 5-clk glitch: false start
        base = sh_cyc.size();
        rx_i = 1'b0;
        repeat (5) @(negedge clk);
        rx_i = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("glitch_shcnt", 32'(sh_cyc.size() - base), 32'd0);
        check_eq("glitch_rdy", 32'(rx_rdy_o), 32'd0);

        // Framing error then good frame
        send_frame(8'hA3, 1'b0, 16);
        check_eq("fe_data", 32'(rx_data_o), 32'hA3);
        check_eq("fe_ferr", 32'(ferr_o), 32'd1);
        check_eq("fe_rdy", 32'(rx_rdy_o), 32'd1);
        pulse_rd();
        send_frame(8'h01, 1'b1, 16);
        check_eq("f01_data", 32'(rx_data_o), 32'h01);
        check_eq("f01_ferr", 32'(ferr_o), 32'd0);
        pulse_rd();

        // Overrun: newest byte wins
        send_frame(8'h11, 1'b1, 16);
        send_frame(8'h22, 1'b1, 16);
        check_eq("ovf_data", 32'(rx_data_o), 32'h22);
        check_eq("ovf_ovf", 32'(ovf_o), 32'd1);
        check_eq("ovf_rdy", 32'(rx_rdy_o), 32'd1);
        pulse_rd();
        check_eq("ovfrd_rdy", 32'(rx_rdy_o), 32'd0);
        check_eq("ovfrd_ovf", 32'(ovf_o), 32'd0);

        // rd exactly in LOAD with ovf already set: load wins, ovf cleared
        send_frame(8'h33, 1'b1, 16);
        send_frame(8'h44, 1'b1, 16);
        check_eq("pre_ovf", 32'(ovf_o), 32'd1);
        fork
            send_frame(8'h5A, 1'b1, 16);
            rd_at_load();
        join
        check_eq("rdload_data", 32'(rx_data_o), 32'h5A);
        check_eq("rdload_rdy", 32'(rx_rdy_o), 32'd1);
        check_eq("rdload_ovf", 32'(ovf_o), 32'd0);

        // Reset after the 4th sh of 0x3C aborts the frame
        base = sh_cyc.size();
        send_bits({1'b1, 8'h3C, 1'b0}, 4, 16);
        rx_i = 1'b1;
        check_eq("abort_shcnt", 32'(sh_cyc.size() - base), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_data", 32'(rx_data_o), 32'd0);
        check_eq("abort_rdy", 32'(rx_rdy_o), 32'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("abort_quiet", 32'(sh_cyc.size() - base), 32'd4);

        // bit_time below the minimum behaves as 4 clk/bit
        bit_time_i = 19'd2;
        base = sh_cyc.size();
        send_frame(8'h7E, 1'b1, 4);
        check_frame("f7e", base, 4);
        check_eq("f7e_data", 32'(rx_data_o), 32'h7E);
        check_eq("f7e_rdy", 32'(rx_rdy_o), 32'd1);
        check_eq("f7e_ferr", 32'(ferr_o), 32'd0);
        check_eq("f7e_ovf", 32'(ovf_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
